// File: rtl/waveform_accumulator.sv
// Trigger-synchronous waveform averager: sums N fixed-length records point-by-point
// into an accumulator RAM, then streams the summed record out over valid/ready.
module waveform_accumulator #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int ADDR_W = 7,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              trig,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] record_len,
    input  logic [CNT_W-1:0]  num_events,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [CNT_W-1:0]  events_captured
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PAD_W = ACC_W + 1 - DATA_W;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_CHECK   = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;

    localparam logic [ACC_W:0]  SAT_LIMIT = {1'b0, {ACC_W{1'b1}}};
    localparam logic [ADDR_W:0] LEN_FULL  = {1'b1, {ADDR_W{1'b0}}};

    logic [2:0]        state_reg;
    logic [ADDR_W:0]   len_reg;
    logic [CNT_W-1:0]  nev_reg;
    logic [ADDR_W:0]   cap_idx_reg;
    logic [ADDR_W:0]   drain_idx_reg;
    logic              wr_pending_reg;
    logic              wr_first_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [DATA_W-1:0] wr_sample_reg;
    logic [ACC_W-1:0]  rd_data_reg;
    logic              out_valid_reg;
    logic              out_last_reg;
    logic              done_reg;
    logic              overflow_reg;
    logic [CNT_W-1:0]  events_reg;

    logic [ACC_W-1:0]  acc_ram [0:DEPTH-1];

    logic              cap_point;
    logic              drain_adv;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [ACC_W:0]    sum_next;
    logic              sat_next;
    logic [ACC_W-1:0]  wr_data_next;
    logic [CNT_W-1:0]  events_next;
    logic [ADDR_W:0]   len_in;
    logic [CNT_W-1:0]  nev_in;

    assign len_in      = (record_len == '0) ? LEN_FULL : {1'b0, record_len};
    assign nev_in      = (num_events == '0) ? CNT_W'(1) : num_events;
    assign events_next = events_reg + CNT_W'(1);

    assign cap_point = ((state_reg == S_ARMED) && trig) || (state_reg == S_CAPTURE);
    assign drain_adv = (state_reg == S_DRAIN) && (!out_valid_reg || out_ready)
                       && (drain_idx_reg < len_reg);
    assign rd_en     = cap_point || drain_adv;

    always_comb begin
        rd_addr = cap_idx_reg[ADDR_W-1:0];
        if (state_reg == S_DRAIN)
            rd_addr = drain_idx_reg[ADDR_W-1:0];
        else if (state_reg == S_ARMED)
            rd_addr = '0;
    end

    // Second half of the read-modify-write: the RAM word read last cycle meets its sample.
    always_comb begin
        sum_next = {{PAD_W{1'b0}}, wr_sample_reg};
        if (!wr_first_reg)
            sum_next = {1'b0, rd_data_reg} + {{PAD_W{1'b0}}, wr_sample_reg};
        sat_next     = (sum_next > SAT_LIMIT);
        wr_data_next = sat_next ? {ACC_W{1'b1}} : sum_next[ACC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (wr_pending_reg)
            acc_ram[wr_addr_reg] <= wr_data_next;
    end

    // Read enable doubles as the output hold during DRAIN backpressure.
    always_ff @(posedge clk) begin
        if (rst)
            rd_data_reg <= '0;
        else if (rd_en)
            rd_data_reg <= acc_ram[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            len_reg        <= '0;
            nev_reg        <= '0;
            cap_idx_reg    <= '0;
            drain_idx_reg  <= '0;
            wr_pending_reg <= 1'b0;
            wr_first_reg   <= 1'b0;
            wr_addr_reg    <= '0;
            wr_sample_reg  <= '0;
            out_valid_reg  <= 1'b0;
            out_last_reg   <= 1'b0;
            done_reg       <= 1'b0;
            overflow_reg   <= 1'b0;
            events_reg     <= '0;
        end else begin
            done_reg       <= 1'b0;
            wr_pending_reg <= 1'b0;
            if (wr_pending_reg && sat_next)
                overflow_reg <= 1'b1;

            if (abort && (state_reg != S_IDLE)) begin
                state_reg     <= S_IDLE;
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (start && !abort) begin
                            len_reg      <= len_in;
                            nev_reg      <= nev_in;
                            overflow_reg <= 1'b0;
                            events_reg   <= '0;
                            state_reg    <= S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        if (trig) begin
                            wr_pending_reg <= 1'b1;
                            wr_addr_reg    <= '0;
                            wr_first_reg   <= (events_reg == '0);
                            wr_sample_reg  <= sample_in;
                            cap_idx_reg    <= (ADDR_W+1)'(1);
                            state_reg      <= (len_reg == (ADDR_W+1)'(1)) ? S_CHECK : S_CAPTURE;
                        end
                    end
                    S_CAPTURE: begin
                        wr_pending_reg <= 1'b1;
                        wr_addr_reg    <= cap_idx_reg[ADDR_W-1:0];
                        wr_first_reg   <= (events_reg == '0);
                        wr_sample_reg  <= sample_in;
                        cap_idx_reg    <= cap_idx_reg + (ADDR_W+1)'(1);
                        if (cap_idx_reg == len_reg - (ADDR_W+1)'(1))
                            state_reg <= S_CHECK;
                    end
                    S_CHECK: begin
                        events_reg <= events_next;
                        if (events_next == nev_reg) begin
                            drain_idx_reg <= '0;
                            state_reg     <= S_DRAIN;
                        end else begin
                            state_reg <= S_ARMED;
                        end
                    end
                    S_DRAIN: begin
                        if (drain_adv) begin
                            drain_idx_reg <= drain_idx_reg + (ADDR_W+1)'(1);
                            out_valid_reg <= 1'b1;
                            out_last_reg  <= (drain_idx_reg == len_reg - (ADDR_W+1)'(1));
                        end else if (out_valid_reg && out_ready) begin
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            done_reg      <= 1'b1;
                            state_reg     <= S_IDLE;
                        end
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    assign out_data        = out_valid_reg ? rd_data_reg : '0;
    assign out_valid       = out_valid_reg;
    assign out_last        = out_last_reg;
    assign busy            = (state_reg != S_IDLE);
    assign done            = done_reg;
    assign overflow        = overflow_reg;
    assign events_captured = events_reg;

endmodule

// File: tb/tb_waveform_accumulator.sv
// Scoreboard bench for waveform_accumulator: a driver pushes expected records computed
// from plain per-point sums; a negedge monitor pops and compares on every handshake.
module tb_waveform_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  sample_in;
    logic        trig, start, abort;
    logic [6:0]  record_len;
    logic [7:0]  num_events;
    logic [15:0] out_data;
    logic        out_valid, out_ready, out_last, busy, done, overflow;
    logic [7:0]  events_captured;

    logic [7:0]  s2_sample;
    logic        s2_trig, s2_start, s2_abort, s2_ready;
    logic [1:0]  s2_len, s2_nev;
    logic [8:0]  s2_data;
    logic        s2_valid, s2_last, s2_busy, s2_done, s2_ovf;
    logic [1:0]  s2_events;

    waveform_accumulator dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .trig(trig), .start(start),
        .abort(abort), .record_len(record_len), .num_events(num_events),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done), .overflow(overflow),
        .events_captured(events_captured)
    );

    waveform_accumulator #(.DATA_W(8), .ACC_W(9), .ADDR_W(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .sample_in(s2_sample), .trig(s2_trig), .start(s2_start),
        .abort(s2_abort), .record_len(s2_len), .num_events(s2_nev),
        .out_data(s2_data), .out_valid(s2_valid), .out_ready(s2_ready),
        .out_last(s2_last), .busy(s2_busy), .done(s2_done), .overflow(s2_ovf),
        .events_captured(s2_events)
    );

    typedef struct {
        int data;
        bit last;
    } word_t;

    word_t exp_q[$];
    int    smp [0:255][0:127];
    int    total = 0;
    int    bad = 0;
    int    ready_mode = 0;
    int    rpat = 0;
    int    done_cnt = 0;
    int    word_cnt = 0;
    bit    exp_ovf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: each output point is the plain sum over events, clamped at 2^16-1.
    task automatic push_expected(input int len, input int nev);
        word_t w;
        longint s;
        for (int i = 0; i < len; i++) begin
            s = 0;
            for (int e = 0; e < nev; e++) s += smp[e][i];
            if (s > 65535) begin
                exp_ovf = 1'b1;
                s = 65535;
            end
            w.data = int'(s);
            w.last = (i == len - 1);
            exp_q.push_back(w);
        end
    endtask

    // Monitor: one compare per handshake, plus hold checks across stalls.
    logic        prev_stall = 1'b0;
    logic        prev_reset = 1'b0;
    logic [15:0] prev_data;
    logic        prev_last;
    always @(negedge clk) begin
        word_t w;
        if (done) done_cnt++;
        if (prev_stall && !prev_reset) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, prev_data);
            check("hold_last", out_last, prev_last);
        end
        if (out_valid && out_ready && !rst) begin
            check("word_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                $display("word %0d: data=%0d exp=%0d last=%0d", word_cnt, out_data, w.data, out_last);
                check("out_data", out_data, w.data);
                check("out_last", out_last, w.last);
            end
            word_cnt++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        prev_reset = rst || abort;
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    out_ready = (rpat == 0) || (rpat == 3);
                    rpat = (rpat + 1) % 4;
                end
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic scramble_cfg();
        record_len = 7'($urandom);
        num_events = 8'($urandom);
        start      = 1'($urandom_range(0, 1));
    endtask

    // kind: 0 random samples, 1 ramp (sample = index), 2 samples preloaded in smp.
    task automatic run_test(input int rl, input int ne, input int kind, input int rmode);
        int len, nev, d0, waited;
        len = (rl == 0) ? 128 : rl;
        nev = (ne == 0) ? 1 : ne;
        for (int e = 0; e < nev; e++)
            for (int i = 0; i < len; i++)
                if (kind == 0) smp[e][i] = int'($urandom_range(0, 255));
                else if (kind == 1) smp[e][i] = i;
        exp_ovf = 1'b0;
        push_expected(len, nev);
        rpat = 0;
        ready_mode = rmode;
        record_len = 7'(rl);
        num_events = 8'(ne);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        for (int e = 0; e < nev; e++) begin
            repeat ($urandom_range(0, 2)) begin
                trig = 1'b0;
                sample_in = 8'($urandom);
                scramble_cfg();
                tick();
            end
            for (int i = 0; i < len; i++) begin
                trig = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                sample_in = 8'(smp[e][i]);
                scramble_cfg();
                tick();
            end
            trig = 1'($urandom_range(0, 1));
            sample_in = 8'($urandom);
            tick();
        end
        start = 1'b0;
        d0 = done_cnt;
        waited = 0;
        while (done_cnt == d0 && waited < 3000) begin
            trig = 1'($urandom_range(0, 1));
            sample_in = 8'($urandom);
            tick();
            waited++;
        end
        trig = 1'b1;
        repeat (3) tick();
        trig = 1'b0;
        check("done_pulses", done_cnt - d0, 1);
        check("words_left", exp_q.size(), 0);
        check("events_captured", events_captured, nev);
        check("overflow", overflow, exp_ovf);
        check("busy_idle", busy, 0);
        check("valid_idle", out_valid, 0);
        exp_q.delete();
        ready_mode = 0;
    endtask

    initial begin
        int waited, d0;
        rst = 1'b1; sample_in = '0; trig = 1'b0; start = 1'b0; abort = 1'b0;
        record_len = '0; num_events = '0;
        s2_sample = '0; s2_trig = 1'b0; s2_start = 1'b0; s2_abort = 1'b0; s2_ready = 1'b1;
        s2_len = '0; s2_nev = '0;
        repeat (3) tick();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_events", events_captured, 0);
        rst = 1'b0;
        tick();

        // Narrow accumulator: 255 summed three times saturates at 511.
        s2_len = 2'd1; s2_nev = 2'd3; s2_start = 1'b1;
        tick();
        s2_start = 1'b0;
        for (int e = 0; e < 3; e++) begin
            s2_trig = 1'b1; s2_sample = 8'd255;
            tick();
            s2_trig = 1'b0;
            tick();
        end
        waited = 0;
        while (!s2_valid && waited < 10) begin
            tick();
            waited++;
        end
        check("sat_valid", s2_valid, 1);
        check("sat_data", s2_data, 511);
        check("sat_last", s2_last, 1);
        check("sat_overflow", s2_ovf, 1);
        check("sat_events", s2_events, 3);
        tick();
        check("sat_done", s2_done, 1);
        check("sat_busy", s2_busy, 0);

        smp[0][0] = 10; smp[0][1] = 20; smp[0][2] = 30; smp[0][3] = 40;
        run_test(4, 1, 2, 0);

        for (int e = 0; e < 3; e++) begin
            smp[e][0] = 255; smp[e][1] = 1; smp[e][2] = 2;
        end
        run_test(3, 3, 2, 0);

        run_test(8, 1, 0, 2);

        // Abort partway through the second of four events.
        for (int e = 0; e < 2; e++)
            for (int i = 0; i < 5; i++) smp[e][i] = int'($urandom_range(0, 255));
        record_len = 7'd5; num_events = 8'd4; start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 0; e < 2; e++) begin
            for (int i = 0; i < ((e == 0) ? 5 : 3); i++) begin
                trig = (i == 0);
                sample_in = 8'(smp[e][i]);
                tick();
            end
            trig = 1'b0;
            if (e == 0) tick();
        end
        d0 = done_cnt;
        abort = 1'b1;
        start = 1'b1;
        tick();
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
        check("abort_last", out_last, 0);
        check("abort_events_hold", events_captured, 1);
        repeat (4) tick();
        check("abort_idle_with_start", busy, 0);
        abort = 1'b0;
        start = 1'b0;
        tick();
        check("abort_no_done", done_cnt - d0, 0);
        run_test(5, 1, 0, 0);

        run_test(0, 2, 1, 1);

        for (int k = 0; k < 6; k++)
            run_test(int'($urandom_range(0, 9)), int'($urandom_range(0, 4)), 0, 1);

        run_test(1, 255, 0, 1);

        // Reset while a word is stalled in DRAIN.
        record_len = 7'd4; num_events = 8'd1; start = 1'b1;
        ready_mode = 3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            trig = (i == 0);
            sample_in = 8'(i + 1);
            tick();
        end
        trig = 1'b0;
        waited = 0;
        while (!out_valid && waited < 10) begin
            tick();
            waited++;
        end
        check("drain_valid_before_rst", out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("drain_rst_valid", out_valid, 0);
        check("drain_rst_data", out_data, 0);
        check("drain_rst_last", out_last, 0);
        check("drain_rst_busy", busy, 0);
        check("drain_rst_done", done, 0);
        check("drain_rst_events", events_captured, 0);
        ready_mode = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
